bitmask_scanner: RTL
====================

BITMASK_SCANNER -- requirements
Module: bitmask_scanner

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit, meaning a new 32-bit mask is offered.
REQ-004 SHALL have port in_data, input, 32 bits, the mask to scan.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-006 SHALL have port out_valid, output, 1 bit, meaning out_idx/out_last are valid.
REQ-007 SHALL have port out_idx, output, 6 bits, the 1-based set-bit index (1..32), with 0 meaning an empty mask.
REQ-008 SHALL have port out_last, output, 1 bit, marking the final beat for the current mask.
REQ-009 SHALL have port out_ready, input, 1 bit, the downstream accept.

Function
REQ-010 SHALL have two states: IDLE (no mask held) and SCAN (mask register non-final or pending emission).
REQ-011 SHALL assert in_ready in IDLE, or in SCAN when out_valid && out_ready && out_last occur in the same cycle (back-to-back masks, no bubble).
REQ-012 SHALL load mask <= in_data and enter SCAN on in_valid && in_ready; first out_valid appears the following cycle (latency 1).
REQ-013 SHALL drive out_valid = 1 throughout SCAN and 0 in IDLE.
REQ-014 SHALL drive out_idx = 1 + position of the lowest set bit of mask (bit0 -> 1, bit31 -> 32), or 0 when mask == 0.
REQ-015 SHALL drive out_last = 1 when (mask & (mask - 1)) == 0, which covers both the zero mask and the one-bit mask.
REQ-016 SHALL emit exactly one beat (idx 0, last 1) for an all-zero input mask.
REQ-017 SHALL, on out_valid && out_ready && !out_last, update mask <= mask & (mask - 1) using 32-bit wrap arithmetic and stay in SCAN.
REQ-018 SHALL, on out_valid && out_ready && out_last, go to IDLE, unless a new mask is accepted in the same cycle, in which case it loads that mask and stays in SCAN.
REQ-019 SHALL hold mask, out_idx and out_last stable while out_valid && !out_ready (backpressure).
REQ-020 SHALL emit indices in strictly ascending order, one per handshake, with the beat count equal to popcount(mask), or 1 if the mask is zero.
REQ-021 SHALL make out_idx and out_last combinational functions of registered state only, with no path from out_ready.

Reset
REQ-022 SHALL, on reset high at a clock edge, set state = IDLE and mask = 0, giving out_valid = 0 and in_ready = 1 in the next cycle.
REQ-023 SHALL, on reset mid-SCAN, discard the remaining indices, and reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-024 SHALL, with macro BITMASK_SCANNER_CNT_EN defined, add an output port total, 6 bits, giving popcount of the mask at acceptance, registered on load, held through SCAN, and reset to 0.
REQ-025 SHALL, without BITMASK_SCANNER_CNT_EN, omit the total port and its popcount logic entirely; all other behaviour is identical.

Structure
REQ-026 SHALL place in a shared package: the state enum (IDLE, SCAN), the constants MASK_W = 32 and IDX_W = 6, and the IDX_NONE = 0 constant.
REQ-027 SHALL instantiate one sub-module, lsb_index (32-bit in, 6-bit 1-based index out, 0 for zero input), to produce out_idx from mask.

Verification
REQ-028 SHALL cover: mask 32'h0000_0029 with out_ready held at 1 -> beats idx 1, 4, 6 on consecutive cycles; last = 1 only on 6; then IDLE.
REQ-029 SHALL cover: mask 32'h0000_0000 -> single beat idx 0, last 1.
REQ-030 SHALL cover: mask 32'h8000_0001 with out_ready low for 3 cycles -> idx 1 held stable for 3 cycles, then 1 and 32 emitted, with last on 32.
REQ-031 SHALL cover: masks 32'h0000_0004 then 32'hFFFF_FFFF presented back-to-back -> idx 3 (last), next cycle idx 1, then 2..32 in order with no gap cycle; with CNT_EN, total = 1 then 32.
REQ-032 SHALL cover: reset asserted during the second beat of 32'h0000_00F0 -> next cycle out_valid 0 and in_ready 1, with no further beats.
REQ-033 SHALL cover: in_valid high while in SCAN and not on a last handshake -> in_ready 0 and the mask is not taken, and it is accepted on the cycle of the last handshake.

Source files
------------

// File: rtl/bitmask_scanner_pkg.sv
// Shared types and constants for the bitmask scanner: FSM state enum, widths
// and the "empty mask" index value.
package bitmask_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int unsigned MASK_W = 32;
  localparam int unsigned IDX_W  = 6;

  localparam logic [IDX_W-1:0] IDX_NONE = '0;

endpackage

// File: rtl/bitmask_scanner_lsb_index.sv
// Combinational lowest-set-bit finder: 1-based index of the lowest set bit,
// IDX_NONE when the input is all zeros.
module lsb_index
  import bitmask_scanner_pkg::*;
(
  input  logic [MASK_W-1:0] data,
  output logic [IDX_W-1:0]  idx
);

  logic found;

  always_comb begin
    idx   = IDX_NONE;
    found = 1'b0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (!found && data[i]) begin
        idx   = IDX_W'(i + 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitmask_scanner.sv
// Streams the 1-based indices of the set bits of each accepted 32-bit mask,
// lowest first. Optional macro BITMASK_SCANNER_CNT_EN adds a popcount port.
module bitmask_scanner
  import bitmask_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [MASK_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  input  logic              out_ready
`ifdef BITMASK_SCANNER_CNT_EN
  ,
  output logic [IDX_W-1:0]  total
`endif
);

  state_t            state, state_n;
  logic [MASK_W-1:0] mask, mask_n;
  logic              fire;
  logic              accept;

  // Output side depends only on registered state; out_ready only steers in_ready.
  assign out_valid = (state == SCAN);
  assign out_last  = ((mask & (mask - 32'd1)) == '0);
  assign fire      = out_valid && out_ready;
  assign in_ready  = (state == IDLE) || (fire && out_last);
  assign accept    = in_valid && in_ready;

  lsb_index u_lsb_index (
    .data (mask),
    .idx  (out_idx)
  );

  always_comb begin
    state_n = state;
    mask_n  = mask;
    if (accept) begin
      state_n = SCAN;
      mask_n  = in_data;
    end else if (fire) begin
      if (out_last) begin
        state_n = IDLE;
        mask_n  = '0;
      end else begin
        mask_n  = mask & (mask - 32'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
    end
  end

`ifdef BITMASK_SCANNER_CNT_EN
  logic [IDX_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      pop = pop + IDX_W'(in_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total <= '0;
    end else if (accept) begin
      total <= pop;
    end
  end
`endif

endmodule
